jtag_axi_dispatch: RTL

// - AXI4-Lite master sequencer for the JTAG debug path: accepts one command (addr, data, dir, strobe)

---
 rtl/jtag_pkg.sv | 25 ++
 rtl/jtag_axi_dispatch.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG debug-path types: AXI dispatcher status codes, FSM states and AXI response encodings.
package jtag_pkg;

   typedef enum logic [1:0] {
      AXI_OKAY    = 2'b00,
      AXI_SLVERR  = 2'b01,
      AXI_DECERR  = 2'b10,
      AXI_TIMEOUT = 2'b11
   } axi_dispatch_status_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP,
      RSP
   } axi_dispatch_fsm_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/jtag_axi_dispatch.sv
// AXI4-Lite master sequencer for the JTAG debug path: one command in, one AXI-Lite transaction out,
// one response back, with a watchdog that aborts transactions to hung slaves.
module jtag_axi_dispatch
   import jtag_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_wr,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output axi_dispatch_status_t      rsp_status,
   output logic [ADDR_WIDTH-1:0]     m_awaddr,
   output logic [2:0]                m_awprot,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [DATA_WIDTH-1:0]     m_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_wstrb,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   input  logic [1:0]                m_bresp,
   input  logic                      m_bvalid,
   output logic                      m_bready,
   output logic [ADDR_WIDTH-1:0]     m_araddr,
   output logic [2:0]                m_arprot,
   output logic                      m_arvalid,
   input  logic                      m_arready,
   input  logic [DATA_WIDTH-1:0]     m_rdata,
   input  logic [1:0]                m_rresp,
   input  logic                      m_rvalid,
   output logic                      m_rready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

   function automatic axi_dispatch_status_t map_resp(input logic [1:0] resp);
      case (resp)
         AXI_RESP_SLVERR: map_resp = AXI_SLVERR;
         AXI_RESP_DECERR: map_resp = AXI_DECERR;
         default:         map_resp = AXI_OKAY;   // OKAY and EXOKAY both report success
      endcase
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      sat_inc = (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   axi_dispatch_fsm_t     state_q, state_d;
   logic                  aw_done_q, w_done_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   axi_dispatch_status_t  rsp_status_q;
   logic                  cmd_fire, active, expired;

   assign cmd_fire = cmd_valid & cmd_ready;
   assign active   = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                     (state_q == RD_REQ) || (state_q == RD_RESP);
   // Expiry is flagged on the last counted cycle so the abort lands exactly TIMEOUT_CYCLES after issue.
   assign expired  = (TIMEOUT_CYCLES > 0) && (cnt_q >= CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_arvalid = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_d = cmd_wr ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            m_awvalid = ~aw_done_q;
            m_wvalid  = ~w_done_q;
            if (expired)
               state_d = RSP;
            else if ((aw_done_q | m_awready) & (w_done_q | m_wready))
               state_d = WR_RESP;
         end
         WR_RESP: begin
            if (m_bvalid || expired) state_d = RSP;
         end
         RD_REQ: begin
            m_arvalid = 1'b1;
            if (expired)        state_d = RSP;
            else if (m_arready) state_d = RD_RESP;
         end
         RD_RESP: begin
            if (m_rvalid || expired) state_d = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake tracking, watchdog and response capture; a response beating expiry keeps its own status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         cnt_q        <= '0;
         rsp_rdata_q  <= '0;
         rsp_status_q <= AXI_OKAY;
      end else begin
         if (cmd_fire) begin
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
         end else if (active) begin
            cnt_q <= sat_inc(cnt_q);
         end
         if (m_awvalid && m_awready) aw_done_q <= 1'b1;
         if (m_wvalid && m_wready)   w_done_q  <= 1'b1;
         if (state_q == WR_RESP && m_bvalid) begin
            rsp_status_q <= map_resp(m_bresp);
         end else if (state_q == RD_RESP && m_rvalid) begin
            rsp_status_q <= map_resp(m_rresp);
            rsp_rdata_q  <= m_rdata;
         end else if (active && expired) begin
            rsp_status_q <= AXI_TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cmd_fire) begin
         addr_q  <= cmd_addr;
         wdata_q <= cmd_wdata;
         wstrb_q <= cmd_wstrb;
      end
   end

   assign m_awaddr   = addr_q;
   assign m_araddr   = addr_q;
   assign m_wdata    = wdata_q;
   assign m_wstrb    = wstrb_q;
   assign m_awprot   = 3'b000;
   assign m_arprot   = 3'b000;
   // Ready stays high in every state so stray beats after an abort drain harmlessly.
   assign m_bready   = 1'b1;
   assign m_rready   = 1'b1;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_status = rsp_status_q;

endmodule
